// File: rtl/puf_pkg.sv
// Shared types and defaults for the PUF response controller.
package puf_pkg;

  localparam int unsigned WINDOW_CYCLES_DEF = 256;
  localparam int unsigned SETTLE_CYCLES_DEF = 4;
  localparam int unsigned CNT_W_DEF         = 16;
  localparam int unsigned NBITS_DEF         = 8;
  localparam int unsigned SEL_W             = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } puf_state_e;

  // Oscillator index for bit k; wraps modulo the bank size.
  function automatic logic [SEL_W-1:0] sel_of(input logic [SEL_W-1:0] chal,
                                               input logic [SEL_W-1:0] k);
    return chal + k;
  endfunction

endpackage

// File: rtl/puf_response_ctrl_if.sv
// Request/response handshake between a consumer and the PUF controller.
interface puf_response_ctrl_if
  import puf_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEF
);
  logic             start;
  logic [SEL_W-1:0] challenge;
  logic             resp_ack;
  logic             busy;
  logic [NBITS-1:0] resp;
  logic             resp_valid;
  logic             tie;

  modport master (output start, challenge, resp_ack,
                  input  busy, resp, resp_valid, tie);
  modport slave  (input  start, challenge, resp_ack,
                  output busy, resp, resp_valid, tie);
endinterface

// File: rtl/puf_edge_counter.sv
// Synchronizes an oscillator output and counts its rising edges, saturating.
module puf_edge_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro,
  input  logic             clr,
  input  logic             cnt_en,
  output logic [CNT_W-1:0] cnt
);

  // [0],[1] form the two-flop synchronizer, [2] holds the previous sample.
  logic [2:0] sync_q;
  logic       rise_c;

  assign rise_c = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[1:0], ro};
      if (clr) begin
        cnt <= '0;
      end else if (cnt_en && rise_c && (cnt != '1)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/puf_response_ctrl.sv
// Ring-oscillator PUF controller: one settle/measure/compare pass per response bit.
module puf_response_ctrl
  import puf_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = WINDOW_CYCLES_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF,
  parameter int unsigned NBITS         = NBITS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic [SEL_W-1:0] ro_sel,
  output logic             ro_en,
  puf_response_ctrl_if.slave bus
);

  localparam logic [2:0] IDLE    = 3'(ST_IDLE);
  localparam logic [2:0] SETTLE  = 3'(ST_SETTLE);
  localparam logic [2:0] MEASURE = 3'(ST_MEASURE);
  localparam logic [2:0] COMPARE = 3'(ST_COMPARE);
  localparam logic [2:0] DONE    = 3'(ST_DONE);

  localparam int unsigned CYC_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam int unsigned K_W     = (NBITS > 1) ? $clog2(NBITS) : 1;

  logic [2:0]       state_q, state_n;
  logic [SEL_W-1:0] chal_q, chal_n;
  logic [K_W-1:0]   k_q, k_n;
  logic [CYC_W-1:0] cyc_q, cyc_n;
  logic [NBITS-1:0] resp_q, resp_n;
  logic             tie_q, tie_n;
  logic             busy_q, valid_q;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic             cnt_clr_c, cnt_en_c;

  // Counters stay cleared outside a window and hold their totals through COMPARE/DONE.
  assign cnt_clr_c = (state_q == IDLE) || (state_q == SETTLE);
  assign cnt_en_c  = (state_q == MEASURE);

  puf_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk(clk), .rst_n(rst_n), .ro(ro_a), .clr(cnt_clr_c), .cnt_en(cnt_en_c), .cnt(cnt_a)
  );

  puf_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk(clk), .rst_n(rst_n), .ro(ro_b), .clr(cnt_clr_c), .cnt_en(cnt_en_c), .cnt(cnt_b)
  );

  always_comb begin
    state_n = state_q;
    chal_n  = chal_q;
    k_n     = k_q;
    cyc_n   = cyc_q;
    resp_n  = resp_q;
    tie_n   = tie_q;
    case (state_q)
      IDLE: begin
        if (bus.start && ena) begin
          state_n = SETTLE;
          chal_n  = bus.challenge;
          k_n     = '0;
          cyc_n   = '0;
          resp_n  = '0;
          tie_n   = 1'b0;
        end
      end
      SETTLE: begin
        if (cyc_q == CYC_W'(SETTLE_CYCLES - 1)) begin
          state_n = MEASURE;
          cyc_n   = '0;
        end else begin
          cyc_n = cyc_q + CYC_W'(1);
        end
      end
      MEASURE: begin
        if (cyc_q == CYC_W'(WINDOW_CYCLES - 1)) begin
          state_n = COMPARE;
          cyc_n   = '0;
        end else begin
          cyc_n = cyc_q + CYC_W'(1);
        end
      end
      COMPARE: begin
        resp_n[k_q] = (cnt_a > cnt_b);
        if (cnt_a == cnt_b) tie_n = 1'b1;
        if (k_q == K_W'(NBITS - 1)) begin
          state_n = DONE;
        end else begin
          k_n     = k_q + K_W'(1);
          state_n = SETTLE;
        end
      end
      DONE: begin
        if (bus.resp_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // A held response survives ena dropping; everything else aborts.
    if (!ena && (state_q != DONE)) begin
      state_n = IDLE;
      cyc_n   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      chal_q  <= '0;
      k_q     <= '0;
      cyc_q   <= '0;
      resp_q  <= '0;
      tie_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      ro_en   <= 1'b0;
      ro_sel  <= '0;
    end else begin
      state_q <= state_n;
      chal_q  <= chal_n;
      k_q     <= k_n;
      cyc_q   <= cyc_n;
      resp_q  <= resp_n;
      tie_q   <= tie_n;
      busy_q  <= (state_n != IDLE);
      valid_q <= (state_n == DONE);
      ro_en   <= (state_n == SETTLE) || (state_n == MEASURE);
      ro_sel  <= sel_of(chal_n, SEL_W'(k_n));
    end
  end

  assign bus.busy       = busy_q;
  assign bus.resp       = resp_q;
  assign bus.resp_valid = valid_q;
  assign bus.tie        = tie_q;

endmodule

// File: tb/tb_puf_response_ctrl.sv
// Scoreboard bench for puf_response_ctrl: directed runs with hand-computed responses.
module tb_puf_response_ctrl;
  import puf_pkg::*;

  typedef struct {
    logic [7:0] resp;
    logic       tie;
    bit         abort;
    logic [4:0] chal;
    int         t0;
    int         lat;
    int         hold;
  } exp_t;

  localparam int RUN_LAT  = 8 * (4 + 256 + 1);   // 2088
  localparam int RUN2_LAT = 2 * (2 + 50 + 1);    // 106

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ena = 1'b0;
  logic ro_a = 1'b0, ro_b = 1'b0, ro2_a = 1'b0, ro2_b = 1'b0;
  logic [4:0] ro_sel, ro_sel2;
  logic ro_en, ro_en2;

  int cyc = 0;
  int n_chk = 0, n_pass = 0;
  exp_t q[$];
  exp_t q2[$];
  exp_t last;

  int pa = 8, pb = 10, ta = 0, tb = 0, t2 = 0;
  logic la = 1'b0;
  bit same_ab = 1'b0;

  puf_response_ctrl_if #(.NBITS(8)) bus ();
  puf_response_ctrl_if #(.NBITS(2)) bus2 ();

  puf_response_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ro_a(ro_a), .ro_b(ro_b),
    .ro_sel(ro_sel), .ro_en(ro_en), .bus(bus.slave)
  );

  puf_response_ctrl #(.WINDOW_CYCLES(50), .SETTLE_CYCLES(2), .CNT_W(4), .NBITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ro_a(ro2_a), .ro_b(ro2_b),
    .ro_sel(ro_sel2), .ro_en(ro_en2), .bus(bus2.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Oscillator models, stepped on the falling edge.
  initial forever begin
    @(negedge clk);
    ta = (ta + 1 >= pa) ? 0 : ta + 1;
    tb = (tb + 1 >= pb) ? 0 : tb + 1;
    ro_a = (pa == 0) ? la : logic'(ta < pa / 2);
    ro_b = same_ab ? ro_a : ((pb == 0) ? 1'b0 : logic'(tb < pb / 2));
    t2++;
    ro2_a = ~ro2_a;
    ro2_b = logic'((t2 % 4) < 2);
  end

  initial begin
    repeat (40000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1);
  end

  // Main DUT monitor: ro_sel stepping, completion, hold and abort behaviour.
  initial begin
    bit pb_q = 1'b0, pv_q = 1'b0, pe_q = 1'b0;
    int k = 0, vcnt = 0;
    exp_t e;
    logic [4:0] es;
    forever begin
      @(posedge clk); #1;
      if (ro_en && !pe_q) begin
        if (q.size() > 0) begin
          es = q[0].chal + 5'(k);
          chk("ro_sel", int'(ro_sel), int'(es));
        end else chk("ro_en_unexpected", int'(ro_en), 0);
        k++;
      end
      if (bus.resp_valid) vcnt++;
      if (bus.resp_valid && !pv_q) begin
        if (q.size() == 0) chk("valid_unexpected", int'(bus.resp_valid), 0);
        else begin
          e = q.pop_front();
          last = e;
          if (e.abort) chk("valid_on_aborted_run", int'(bus.resp_valid), 0);
          chk("resp", int'(bus.resp), int'(e.resp));
          chk("tie", int'(bus.tie), int'(e.tie));
          chk("valid_latency", cyc - e.t0, e.lat);
          chk("bits_measured", k, 8);
        end
        k = 0;
      end
      if (!bus.resp_valid && pv_q) begin
        chk("valid_hold", vcnt, last.hold);
        chk("resp_kept", int'(bus.resp), int'(last.resp));
        chk("busy_after_ack", int'(bus.busy), 0);
        vcnt = 0;
      end
      if (!bus.busy && pb_q && !pv_q) begin
        if (q.size() == 0) chk("busy_drop_unexpected", int'(bus.busy), 1);
        else begin
          e = q.pop_front();
          if (!e.abort) chk("busy_dropped_early", int'(bus.busy), 1);
          chk("abort_latency", cyc - e.t0, e.lat);
          chk("abort_ro_en", int'(ro_en), 0);
        end
        k = 0;
      end
      pb_q = bus.busy;
      pv_q = bus.resp_valid;
      pe_q = ro_en;
    end
  end

  // Small-parameter DUT monitor: saturation of a 4-bit counter.
  initial begin
    bit pv2 = 1'b0;
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (bus2.resp_valid && !pv2) begin
        if (q2.size() == 0) chk("sat_valid_unexpected", int'(bus2.resp_valid), 0);
        else begin
          e = q2.pop_front();
          chk("sat_resp", int'(bus2.resp), int'(e.resp));
          chk("sat_tie", int'(bus2.tie), int'(e.tie));
          chk("sat_latency", cyc - e.t0, e.lat);
          chk("sat_ro_sel", int'(ro_sel2), int'(e.chal) + 1);
          chk("sat_ro_en", int'(ro_en2), 0);
        end
      end
      pv2 = bus2.resp_valid;
    end
  end

  task automatic wait_valid(input string name, input int budget);
    for (int i = 0; i < budget && !bus.resp_valid; i++) @(negedge clk);
    if (!bus.resp_valid) chk(name, int'(bus.resp_valid), 1);
  endtask

  task automatic do_run(input logic [4:0] ch, input logic [7:0] er, input logic et,
                        input int hold, input bit noise);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1; bus.challenge = ch;
    e.resp = er; e.tie = et; e.abort = 1'b0; e.chal = ch;
    e.t0 = cyc + 1; e.lat = RUN_LAT; e.hold = hold + 1;
    q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0; bus.challenge = 5'h1f;
    if (noise) begin
      repeat (500) @(negedge clk);
      bus.start = 1'b1; bus.challenge = 5'd0; bus.resp_ack = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.resp_ack = 1'b0;
    end
    wait_valid("valid_timeout", RUN_LAT + 100);
    repeat (hold) @(negedge clk);
    bus.resp_ack = 1'b1;
    @(negedge clk);
    bus.resp_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_abort(input logic [4:0] ch, input int n, input bit use_rst);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1; bus.challenge = ch;
    e.resp = 8'h00; e.tie = 1'b0; e.abort = 1'b1; e.chal = ch;
    e.t0 = cyc + 1; e.lat = n + 1; e.hold = 0;
    q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (n) @(negedge clk);
    if (use_rst) begin
      rst_n = 1'b0;
      #1;
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_resp", int'(bus.resp), 0);
      chk("rst_ro_sel", int'(ro_sel), 0);
      chk("rst_ro_en", int'(ro_en), 0);
      chk("rst_tie", int'(bus.tie), 0);
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      ena = 1'b0;
      @(negedge clk);
      ena = 1'b1;
    end
    repeat (3) @(negedge clk);
  endtask

  // Small DUT: ro2_a yields ~25 edges (saturates at 15), ro2_b ~12-13; a wrap would lose.
  initial begin
    exp_t e;
    bus2.start = 1'b0; bus2.challenge = '0; bus2.resp_ack = 1'b0;
    wait (rst_n === 1'b1 && ena === 1'b1);
    @(negedge clk);
    bus2.start = 1'b1; bus2.challenge = 5'd12;
    e.resp = 8'h03; e.tie = 1'b0; e.abort = 1'b0; e.chal = 5'd12;
    e.t0 = cyc + 1; e.lat = RUN2_LAT; e.hold = 0;
    q2.push_back(e);
    @(negedge clk);
    bus2.start = 1'b0;
    for (int i = 0; i < RUN2_LAT + 20 && !bus2.resp_valid; i++) @(negedge clk);
    if (!bus2.resp_valid) chk("sat_valid_timeout", int'(bus2.resp_valid), 1);
    bus2.resp_ack = 1'b1;
    @(negedge clk);
    bus2.resp_ack = 1'b0;
  end

  initial begin
    bus.start = 1'b0; bus.challenge = '0; bus.resp_ack = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_valid", int'(bus.resp_valid), 0);
    chk("reset_resp", int'(bus.resp), 0);
    chk("reset_tie", int'(bus.tie), 0);
    chk("reset_ro_en", int'(ro_en), 0);
    chk("reset_ro_sel", int'(ro_sel), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1; ena = 1'b1;
    repeat (2) @(negedge clk);

    pa = 8; pb = 10;                              // 32 vs ~25 edges per window
    do_run(5'd3, 8'hFF, 1'b0, 0, 1'b0);
    same_ab = 1'b1;                               // identical inputs -> all ties
    do_run(5'd30, 8'h00, 1'b1, 0, 1'b0);
    same_ab = 1'b0;
    pa = 0; la = 1'b1; pb = 6;                    // A silent, B toggling; stray start/ack mid-run
    do_run(5'd21, 8'h00, 1'b0, 0, 1'b1);
    pa = 8; pb = 10;
    do_abort(5'd14, 900, 1'b0);                   // ena drop inside bit 3 window
    do_run(5'd7, 8'hFF, 1'b0, 2, 1'b0);
    do_abort(5'd9, 400, 1'b1);                    // reset inside bit 1 window
    pa = 10; pb = 8;                              // ~25 vs 32 edges; slow consumer
    do_run(5'd0, 8'h00, 1'b0, 50, 1'b0);

    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("sat_queue_drained", q2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
